regfile_mp: RTL and testbench

//  Parametrised multi-read-port register file for the ARM datapath: 2^ADDR_W words of DATA_W bits,
//  one write port, N_RD independent read ports. Replaces the fixed 32-bit-select mux tree with a

---
 rtl/regfile_pkg.sv | 8 +
 rtl/regfile_mp_if.sv | 16 +
 rtl/regfile_mp_muxn_1.sv | 24 ++
 rtl/regfile_mp.sv | 47 ++++
 tb/tb_regfile_mp.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, index/word types and the zero-register index for regfile_mp.
package regfile_pkg;
    localparam int RF_DATA_W = 64;
    localparam int RF_ADDR_W = 5;
    typedef logic [RF_ADDR_W-1:0] reg_idx_t;
    typedef logic [RF_DATA_W-1:0] reg_word_t;
    localparam reg_idx_t XZR_IDX = '1;
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: write port plus N_RD read ports between decode (master) and register file (slave).
interface regfile_mp_if import regfile_pkg::*; #(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int N_RD   = 2
);
    logic                             wr_en;
    logic [ADDR_W-1:0]                wr_addr;
    logic [DATA_W-1:0]                wr_data;
    logic [N_RD-1:0]                  rd_en;
    logic [N_RD-1:0][ADDR_W-1:0]      rd_addr;
    logic [N_RD-1:0][DATA_W-1:0]      rd_data;
    logic [N_RD-1:0]                  rd_valid;
    modport master (output wr_en, wr_addr, wr_data, rd_en, rd_addr, input rd_data, rd_valid);
    modport slave  (input wr_en, wr_addr, wr_data, rd_en, rd_addr, output rd_data, rd_valid);
endinterface

// File: rtl/regfile_mp_muxn_1.sv
// muxn_1: generic N:1 W-bit select mux; 8:1 then 4:1 tree for the 32-entry case.
module muxn_1 #(
    parameter int N = 32,
    parameter int W = 64,
    localparam int SW = $clog2(N)
)(
    input  logic [N-1:0][W-1:0] din,
    input  logic [SW-1:0]       sel,
    output logic [W-1:0]        dout
);
    if (N == 32) begin : g_tree
        logic [W-1:0] l1 [4];
        for (genvar g = 0; g < 4; g++) begin : g_l1
            localparam logic [1:0] G = 2'(g);
            assign l1[g] = din[{G, sel[2:0]}];
        end
        assign dout = l1[sel[4:3]];
    end else begin : g_flat
        always_comb begin
            dout = '0;
            for (int i = 0; i < N; i++) dout = (sel == SW'(i)) ? din[i] : dout;
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: 2^ADDR_W x DATA_W register file, one write port, N_RD read ports with
// optional zero register, write-to-read bypass and registered read output.
module regfile_mp import regfile_pkg::*; #(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int N_RD     = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    parameter bit REG_OUT  = 1'b0
)(
    input logic         clk,
    input logic         rst_n,
    regfile_mp_if.slave bus
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] TOP = '1;
    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [DATA_W-1:0]            mux_q [N_RD];
    logic [N_RD-1:0][DATA_W-1:0]  res, rd_q;
    logic [N_RD-1:0]              vld;
    logic                         wr_hit, fwd_en;
    assign wr_hit = bus.wr_en && !(ZERO_REG && bus.wr_addr == TOP);
    // The registered path always sees post-write data, so forwarding is forced on when REG_OUT=1.
    assign fwd_en = (BYPASS || REG_OUT) && bus.wr_en && rst_n;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) mem <= '0;
        else if (wr_hit) mem[bus.wr_addr] <= bus.wr_data;
    for (genvar p = 0; p < N_RD; p++) begin : g_rd
        muxn_1 #(.N(DEPTH), .W(DATA_W)) u_mux (.din(mem), .sel(bus.rd_addr[p]), .dout(mux_q[p]));
    end
    always_comb begin
        res = '0;
        for (int p = 0; p < N_RD; p++)
            res[p] = (ZERO_REG && bus.rd_addr[p] == TOP) ? '0 :
                     (fwd_en && bus.wr_addr == bus.rd_addr[p]) ? bus.wr_data : mux_q[p];
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rd_q <= '0;
            vld  <= '0;
        end else begin
            vld <= bus.rd_en;
            for (int p = 0; p < N_RD; p++) rd_q[p] <= bus.rd_en[p] ? res[p] : rd_q[p];
        end
    assign bus.rd_data  = REG_OUT ? rd_q : res;
    assign bus.rd_valid = REG_OUT ? vld : '1;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of regfile_mp in bypass, no-bypass and registered-read builds.
module tb_regfile_mp;
    import regfile_pkg::*;
    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            wr_en;
    reg_idx_t        wr_addr;
    reg_word_t       wr_data;
    logic [1:0]      rd_en;
    logic [1:0][4:0] rd_addr;
    int              n_checks = 0;
    int              n_fail = 0;

    always #5 clk = ~clk;

    regfile_mp_if if0 ();
    regfile_mp_if if1 ();
    regfile_mp_if if2 ();
    assign if0.wr_en = wr_en;     assign if1.wr_en = wr_en;     assign if2.wr_en = wr_en;
    assign if0.wr_addr = wr_addr; assign if1.wr_addr = wr_addr; assign if2.wr_addr = wr_addr;
    assign if0.wr_data = wr_data; assign if1.wr_data = wr_data; assign if2.wr_data = wr_data;
    assign if0.rd_en = rd_en;     assign if1.rd_en = rd_en;     assign if2.rd_en = rd_en;
    assign if0.rd_addr = rd_addr; assign if1.rd_addr = rd_addr; assign if2.rd_addr = rd_addr;

    regfile_mp #(.BYPASS(1'b1), .REG_OUT(1'b0)) dut_byp (.clk(clk), .rst_n(rst_n), .bus(if0));
    regfile_mp #(.BYPASS(1'b0), .REG_OUT(1'b0)) dut_nob (.clk(clk), .rst_n(rst_n), .bus(if1));
    regfile_mp #(.BYPASS(1'b1), .REG_OUT(1'b1)) dut_reg (.clk(clk), .rst_n(rst_n), .bus(if2));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = '1; rd_en = 2'b11; rd_addr = {5'd3, 5'd3};
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (if0.rd_data !== '0) begin n_fail++; $display("FAIL reset_byp_data: got %h exp 0", if0.rd_data); end
        n_checks++; if (if1.rd_data !== '0) begin n_fail++; $display("FAIL reset_nob_data: got %h exp 0", if1.rd_data); end
        n_checks++; if (if2.rd_data !== '0) begin n_fail++; $display("FAIL reset_reg_data: got %h exp 0", if2.rd_data); end
        n_checks++; if (if2.rd_valid !== 2'b00) begin n_fail++; $display("FAIL reset_reg_valid: got %b exp 00", if2.rd_valid); end
        tick; tick;
        n_checks++; if (if2.rd_valid !== 2'b00) begin n_fail++; $display("FAIL reset_hold_valid: got %b exp 00", if2.rd_valid); end
        n_checks++; if (if0.rd_data !== '0) begin n_fail++; $display("FAIL reset_hold_data: got %h exp 0", if0.rd_data); end
        wr_en = 1'b0; rd_en = 2'b00; rst_n = 1'b1;
        tick;
        for (int i = 0; i < 32; i++) begin
            rd_addr = {reg_idx_t'(i), reg_idx_t'(i)};
            #1;
            n_checks++; if (if0.rd_data !== '0) begin n_fail++; $display("FAIL reset_read_%0d: got %h exp 0", i, if0.rd_data); end
            n_checks++; if (if1.rd_data !== '0) begin n_fail++; $display("FAIL reset_read_nob_%0d: got %h exp 0", i, if1.rd_data); end
        end
    endtask

    task automatic test_walk_one;
        reg_word_t exp;
        for (int i = 0; i < 31; i++) begin
            wr_en = 1'b1; wr_addr = reg_idx_t'(i); wr_data = reg_word_t'(1) << i;
            tick;
        end
        wr_en = 1'b0;
        for (int i = 0; i < 31; i++) begin
            rd_addr = {reg_idx_t'(i), reg_idx_t'(i)};
            exp = reg_word_t'(1) << i;
            #1;
            n_checks++; if (if0.rd_data[0] !== exp) begin n_fail++; $display("FAIL walk_p0_%0d: got %h exp %h", i, if0.rd_data[0], exp); end
            n_checks++; if (if0.rd_data[1] !== exp) begin n_fail++; $display("FAIL walk_p1_%0d: got %h exp %h", i, if0.rd_data[1], exp); end
            n_checks++; if (if1.rd_data[0] !== exp) begin n_fail++; $display("FAIL walk_nob_%0d: got %h exp %h", i, if1.rd_data[0], exp); end
        end
        wr_en = 1'b1; wr_addr = XZR_IDX; wr_data = 64'hDEAD; rd_addr = {XZR_IDX, XZR_IDX};
        #1;
        n_checks++; if (if0.rd_data[0] !== '0) begin n_fail++; $display("FAIL xzr_same_cycle: got %h exp 0", if0.rd_data[0]); end
        tick;
        wr_en = 1'b0;
        #1;
        n_checks++; if (if0.rd_data[1] !== '0) begin n_fail++; $display("FAIL xzr_after: got %h exp 0", if0.rd_data[1]); end
        n_checks++; if (if1.rd_data[0] !== '0) begin n_fail++; $display("FAIL xzr_after_nob: got %h exp 0", if1.rd_data[0]); end
    endtask

    task automatic test_bypass;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hA5A5; rd_addr[0] = 5'd5; rd_addr[1] = 5'd6; rd_en = 2'b01;
        #1;
        n_checks++; if (if0.rd_data[0] !== 64'hA5A5) begin n_fail++; $display("FAIL bypass_hit: got %h exp a5a5", if0.rd_data[0]); end
        n_checks++; if (if0.rd_data[1] !== 64'h40) begin n_fail++; $display("FAIL bypass_miss: got %h exp 40", if0.rd_data[1]); end
        n_checks++; if (if1.rd_data[0] !== 64'h20) begin n_fail++; $display("FAIL nobypass_old: got %h exp 20", if1.rd_data[0]); end
        tick;
        wr_en = 1'b0; rd_en = 2'b00;
        #1;
        n_checks++; if (if1.rd_data[0] !== 64'hA5A5) begin n_fail++; $display("FAIL nobypass_new: got %h exp a5a5", if1.rd_data[0]); end
        n_checks++; if (if2.rd_data[0] !== 64'hA5A5) begin n_fail++; $display("FAIL regout_postwrite: got %h exp a5a5", if2.rd_data[0]); end
        n_checks++; if (if2.rd_valid !== 2'b01) begin n_fail++; $display("FAIL regout_postwrite_valid: got %b exp 01", if2.rd_valid); end
    endtask

    task automatic test_reg_out;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h77;
        tick;
        wr_en = 1'b0; rd_en = 2'b10; rd_addr[1] = 5'd7;
        #1;
        n_checks++; if (if2.rd_valid !== 2'b00) begin n_fail++; $display("FAIL regout_pre_valid: got %b exp 00", if2.rd_valid); end
        n_checks++; if (if0.rd_valid !== 2'b11) begin n_fail++; $display("FAIL comb_valid_tied: got %b exp 11", if0.rd_valid); end
        tick;
        n_checks++; if (if2.rd_data[1] !== 64'h77) begin n_fail++; $display("FAIL regout_data: got %h exp 77", if2.rd_data[1]); end
        n_checks++; if (if2.rd_valid !== 2'b10) begin n_fail++; $display("FAIL regout_valid: got %b exp 10", if2.rd_valid); end
        rd_en = 2'b00; rd_addr[1] = 5'd0;
        tick;
        n_checks++; if (if2.rd_valid !== 2'b00) begin n_fail++; $display("FAIL regout_idle_valid: got %b exp 00", if2.rd_valid); end
        n_checks++; if (if2.rd_data[1] !== 64'h77) begin n_fail++; $display("FAIL regout_hold1: got %h exp 77", if2.rd_data[1]); end
        n_checks++; if (if2.rd_data[0] !== 64'hA5A5) begin n_fail++; $display("FAIL regout_hold0: got %h exp a5a5", if2.rd_data[0]); end
    endtask

    task automatic test_same_addr;
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 64'h1234; rd_addr = {5'd12, 5'd12}; rd_en = 2'b11;
        #1;
        n_checks++; if (if0.rd_data !== {64'h1234, 64'h1234}) begin n_fail++; $display("FAIL same_addr_byp: got %h exp both 1234", if0.rd_data); end
        n_checks++; if (if1.rd_data !== {64'h1000, 64'h1000}) begin n_fail++; $display("FAIL same_addr_nob: got %h exp both 1000", if1.rd_data); end
        tick;
        wr_en = 1'b0; rd_en = 2'b00;
        n_checks++; if (if2.rd_data !== {64'h1234, 64'h1234}) begin n_fail++; $display("FAIL same_addr_reg: got %h exp both 1234", if2.rd_data); end
        n_checks++; if (if2.rd_valid !== 2'b11) begin n_fail++; $display("FAIL same_addr_valid: got %b exp 11", if2.rd_valid); end
        n_checks++; if (if1.rd_data !== {64'h1234, 64'h1234}) begin n_fail++; $display("FAIL same_addr_nob_next: got %h exp both 1234", if1.rd_data); end
    endtask

    task automatic test_x_idle;
        wr_en = 1'b0; wr_addr = 'x; wr_data = 'x; rd_en = 2'b00; rd_addr = 'x;
        tick; tick;
        n_checks++; if (if2.rd_data[0] !== 64'h1234) begin n_fail++; $display("FAIL x_idle_hold: got %h exp 1234", if2.rd_data[0]); end
        n_checks++; if (if2.rd_valid !== 2'b00) begin n_fail++; $display("FAIL x_idle_valid: got %b exp 00", if2.rd_valid); end
        rd_addr[0] = 5'd12; rd_addr[1] = 5'd13;
        #1;
        n_checks++; if (if0.rd_data[0] !== 64'h1234) begin n_fail++; $display("FAIL x_idle_r12: got %h exp 1234", if0.rd_data[0]); end
        n_checks++; if (if0.rd_data[1] !== 64'h2000) begin n_fail++; $display("FAIL x_idle_r13: got %h exp 2000", if0.rd_data[1]); end
    endtask

    task automatic test_mid_reset;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h3333; rd_en = 2'b00;
        tick;
        wr_en = 1'b0; rd_en = 2'b11; rd_addr = {5'd3, 5'd3};
        tick;
        n_checks++; if (if2.rd_data !== {64'h3333, 64'h3333} || if2.rd_valid !== 2'b11) begin
            n_fail++; $display("FAIL mid_pre: got %h/%b exp both 3333/11", if2.rd_data, if2.rd_valid); end
        wr_en = 1'b1; wr_data = 64'hBEEF;
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (if2.rd_valid !== 2'b00) begin n_fail++; $display("FAIL mid_valid: got %b exp 00", if2.rd_valid); end
        n_checks++; if (if2.rd_data !== '0) begin n_fail++; $display("FAIL mid_reg_data: got %h exp 0", if2.rd_data); end
        n_checks++; if (if0.rd_data !== '0) begin n_fail++; $display("FAIL mid_byp_data: got %h exp 0", if0.rd_data); end
        @(posedge clk);
        #2;
        wr_en = 1'b0; rst_n = 1'b1;
        #1;
        n_checks++; if (if0.rd_data !== '0) begin n_fail++; $display("FAIL mid_after_byp: got %h exp 0", if0.rd_data); end
        n_checks++; if (if1.rd_data !== '0) begin n_fail++; $display("FAIL mid_after_nob: got %h exp 0", if1.rd_data); end
        tick;
        n_checks++; if (if2.rd_data !== '0 || if2.rd_valid !== 2'b11) begin
            n_fail++; $display("FAIL mid_after_reg: got %h/%b exp 0/11", if2.rd_data, if2.rd_valid); end
    endtask

    initial begin
        test_reset;
        test_walk_one;
        test_bypass;
        test_reg_out;
        test_same_addr;
        test_x_idle;
        test_mid_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
